// File: rtl/phrase_seq.sv
// Phrase-based note sequencer: fetches eight-note phrases from an external
// database and steps through them on eighth-note ticks.
module phrase_seq #(
    parameter logic [3:0] FIRST_PHRASE = 4'd1,
    parameter logic [3:0] LAST_PHRASE  = 4'd13,
    parameter logic       LOOP         = 1'b1,
    parameter logic [3:0] REST_CODE    = 4'hD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        tick,
    output logic [3:0]  phrase_addr,
    input  logic [31:0] db_entry,
    input  logic [7:0]  length_entry,
    input  logic [2:0]  n_note,
    output logic [3:0]  note_code,
    output logic        note_valid,
    output logic        note_start,
    output logic        busy,
    output logic        song_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  phrase_addr_q, phrase_addr_d;
    logic [3:0]  note_code_q, note_code_d;
    logic        note_start_q, note_start_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  rem_q, rem_d;
    logic [31:0] notes_q, notes_d;
    logic [7:0]  lens_q, lens_d;
    logic [2:0]  nn_q, nn_d;
    logic [2:0]  idx_nxt;

    // Note i of a packed phrase word sits in bits [31-4i:28-4i].
    function automatic logic [3:0] nibble(input logic [31:0] entry, input logic [2:0] i);
        logic [31:0] shifted;
        shifted = entry << {i, 2'b00};
        return shifted[31:28];
    endfunction

    function automatic logic [1:0] dur(input logic [7:0] lens, input logic [2:0] i);
        return lens[3'd7 - i] ? 2'd2 : 2'd1;
    endfunction

    assign idx_nxt = idx_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        phrase_addr_d = phrase_addr_q;
        note_code_d   = note_code_q;
        note_start_d  = 1'b0;
        idx_d         = idx_q;
        rem_d         = rem_q;
        notes_d       = notes_q;
        lens_d        = lens_q;
        nn_d          = nn_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_LOAD;
                    phrase_addr_d = FIRST_PHRASE;
                end
            end
            // The database answers phrase_addr during this cycle, so the first
            // note is taken straight from the bus as it is captured.
            S_LOAD: begin
                notes_d      = db_entry;
                lens_d       = length_entry;
                nn_d         = n_note;
                idx_d        = 3'd0;
                note_code_d  = nibble(db_entry, 3'd0);
                rem_d        = dur(length_entry, 3'd0);
                note_start_d = 1'b1;
                state_d      = S_PLAY;
            end
            S_PLAY: begin
                if (tick) begin
                    if (rem_q == 2'd2) begin
                        rem_d = 2'd1;
                    end else if (idx_q != nn_q) begin
                        idx_d        = idx_nxt;
                        note_code_d  = nibble(notes_q, idx_nxt);
                        rem_d        = dur(lens_q, idx_nxt);
                        note_start_d = 1'b1;
                    end else if (phrase_addr_q != LAST_PHRASE) begin
                        phrase_addr_d = phrase_addr_q + 4'd1;
                        state_d       = S_LOAD;
                    end else if (LOOP) begin
                        phrase_addr_d = FIRST_PHRASE;
                        state_d       = S_LOAD;
                    end else begin
                        note_code_d = REST_CODE;
                        rem_d       = 2'd0;
                        state_d     = S_DONE;
                    end
                end
            end
            default: begin
                note_code_d = REST_CODE;
                if (start) begin
                    state_d       = S_LOAD;
                    phrase_addr_d = FIRST_PHRASE;
                end
            end
        endcase

        if (stop) begin
            state_d       = S_IDLE;
            phrase_addr_d = 4'd0;
            note_code_d   = REST_CODE;
            note_start_d  = 1'b0;
            idx_d         = 3'd0;
            rem_d         = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            phrase_addr_q <= 4'd0;
            note_code_q   <= REST_CODE;
            note_start_q  <= 1'b0;
            idx_q         <= 3'd0;
            rem_q         <= 2'd0;
            notes_q       <= 32'd0;
            lens_q        <= 8'd0;
            nn_q          <= 3'd0;
        end else begin
            state_q       <= state_d;
            phrase_addr_q <= phrase_addr_d;
            note_code_q   <= note_code_d;
            note_start_q  <= note_start_d;
            idx_q         <= idx_d;
            rem_q         <= rem_d;
            notes_q       <= notes_d;
            lens_q        <= lens_d;
            nn_q          <= nn_d;
        end
    end

    assign phrase_addr = phrase_addr_q;
    assign note_code   = note_code_q;
    assign note_start  = note_start_q;
    assign note_valid  = !((note_code_q == REST_CODE) || (note_code_q > 4'hD));
    assign busy        = (state_q == S_LOAD) || (state_q == S_PLAY);
    assign song_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_phrase_seq.sv
// Directed bench for phrase_seq: a looping two-phrase instance (a) and a
// one-phrase non-looping instance (b), both fed from the same phrase table.
module tb_phrase_seq;

    logic        clk, rst, stop, tick, start_a, start_b;
    logic [3:0]  addr_a, code_a, addr_b, code_b;
    logic [31:0] db_a, db_b;
    logic [7:0]  len_a, len_b;
    logic [2:0]  nn_a, nn_b;
    logic        valid_a, nst_a, busy_a, done_a;
    logic        valid_b, nst_b, busy_b, done_b;
    int          total, bad;

    function automatic logic [42:0] db_rom(input logic [3:0] a);
        case (a)
            4'd1:    return {32'h5A8C0630, 8'b00001000, 3'd6};
            4'd2:    return {32'h050C8A00, 8'b11000000, 3'd5};
            default: return 43'd0;
        endcase
    endfunction

    assign {db_a, len_a, nn_a} = db_rom(addr_a);
    assign {db_b, len_b, nn_b} = db_rom(addr_b);

    phrase_seq #(.FIRST_PHRASE(4'd1), .LAST_PHRASE(4'd2), .LOOP(1'b1), .REST_CODE(4'hD)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop), .tick(tick),
        .phrase_addr(addr_a), .db_entry(db_a), .length_entry(len_a), .n_note(nn_a),
        .note_code(code_a), .note_valid(valid_a), .note_start(nst_a),
        .busy(busy_a), .song_done(done_a)
    );

    phrase_seq #(.FIRST_PHRASE(4'd1), .LAST_PHRASE(4'd1), .LOOP(1'b0), .REST_CODE(4'hD)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop), .tick(tick),
        .phrase_addr(addr_b), .db_entry(db_b), .length_entry(len_b), .n_note(nn_b),
        .note_code(code_b), .note_valid(valid_b), .note_start(nst_b),
        .busy(busy_b), .song_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the next negedge with the tick consumed.
    task automatic tick_once();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stop = 1'b0; tick = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (addr_a !== 4'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", addr_a); end
        total++; if (code_a !== 4'hD) begin bad++; $display("FAIL reset_code got=%h exp=D", code_a); end
        total++; if ({valid_a, nst_a, busy_a, done_a} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {valid_a, nst_a, busy_a, done_a}); end
        rst = 1'b0;
        @(negedge clk);
        tick_once();
        total++; if (busy_a !== 1'b0 || code_a !== 4'hD) begin bad++; $display("FAIL idle_tick busy=%b code=%h exp busy=0 code=D", busy_a, code_a); end
        @(negedge clk);
    endtask

    task automatic test_phrase1();
        logic [3:0] exp_code [8] = '{4'hA, 4'h8, 4'hC, 4'h0, 4'h0, 4'h6, 4'h3, 4'h3};
        logic       exp_st   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int nstarts;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        total++; if (busy_a !== 1'b1 || addr_a !== 4'd1 || nst_a !== 1'b0) begin bad++; $display("FAIL p1_load busy=%b addr=%h nst=%b exp 1/1/0", busy_a, addr_a, nst_a); end
        @(negedge clk);
        total++; if (code_a !== 4'h5 || nst_a !== 1'b1 || valid_a !== 1'b1) begin bad++; $display("FAIL p1_first code=%h nst=%b vld=%b exp 5/1/1", code_a, nst_a, valid_a); end
        nstarts = 1;
        for (int i = 0; i < 8; i++) begin
            tick_once();
            total++; if (code_a !== exp_code[i] || nst_a !== exp_st[i]) begin bad++; $display("FAIL p1_tick%0d code=%h nst=%b exp %h/%b", i + 1, code_a, nst_a, exp_code[i], exp_st[i]); end
            if (nst_a === 1'b1) nstarts++;
            if (i == 7) begin
                total++; if (addr_a !== 4'd2 || busy_a !== 1'b1) begin bad++; $display("FAIL p1_next_addr got=%h busy=%b exp 2/1", addr_a, busy_a); end
            end
            @(negedge clk);
        end
        total++; if (nstarts !== 7) begin bad++; $display("FAIL p1_start_count got=%0d exp=7", nstarts); end
    endtask

    task automatic test_phrase2();
        logic [3:0] exp_code [8] = '{4'h0, 4'h5, 4'h5, 4'h0, 4'hC, 4'h8, 4'hA, 4'hA};
        logic       exp_st   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        total++; if (code_a !== 4'h0 || nst_a !== 1'b1 || addr_a !== 4'd2) begin bad++; $display("FAIL p2_first code=%h nst=%b addr=%h exp 0/1/2", code_a, nst_a, addr_a); end
        for (int i = 0; i < 8; i++) begin
            tick_once();
            total++; if (code_a !== exp_code[i] || nst_a !== exp_st[i] || valid_a !== 1'b1) begin bad++; $display("FAIL p2_tick%0d code=%h nst=%b vld=%b exp %h/%b/1", i + 1, code_a, nst_a, valid_a, exp_code[i], exp_st[i]); end
            if (i == 7) begin
                total++; if (addr_a !== 4'd1) begin bad++; $display("FAIL p2_wrap_addr got=%h exp=1", addr_a); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_loop();
        total++; if (addr_a !== 4'd1 || code_a !== 4'h5 || nst_a !== 1'b1) begin bad++; $display("FAIL loop_restart addr=%h code=%h nst=%b exp 1/5/1", addr_a, code_a, nst_a); end
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        total++; if (code_a !== 4'h5 || nst_a !== 1'b0 || busy_a !== 1'b1 || addr_a !== 4'd1) begin bad++; $display("FAIL busy_start code=%h nst=%b busy=%b addr=%h exp 5/0/1/1", code_a, nst_a, busy_a, addr_a); end
        @(negedge clk);
    endtask

    task automatic test_stop();
        repeat (4) begin
            tick_once();
            @(negedge clk);
        end
        total++; if (code_a !== 4'h0) begin bad++; $display("FAIL stop_setup code=%h exp=0", code_a); end
        stop = 1'b1; tick = 1'b1;
        @(negedge clk);
        stop = 1'b0; tick = 1'b0;
        total++; if (busy_a !== 1'b0 || code_a !== 4'hD || addr_a !== 4'd0) begin bad++; $display("FAIL stop_state busy=%b code=%h addr=%h exp 0/D/0", busy_a, code_a, addr_a); end
        total++; if (nst_a !== 1'b0 || valid_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL stop_flags nst=%b vld=%b done=%b exp 000", nst_a, valid_a, done_a); end
        @(negedge clk);
        tick_once();
        total++; if (busy_a !== 1'b0 || code_a !== 4'hD) begin bad++; $display("FAIL stop_tick_ignored busy=%b code=%h exp 0/D", busy_a, code_a); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        tick_once();
        total++; if (code_a !== 4'hA || valid_a !== 1'b1) begin bad++; $display("FAIL ar_setup code=%h vld=%b exp A/1", code_a, valid_a); end
        #3 rst = 1'b1;
        #1;
        total++; if (addr_a !== 4'd0 || code_a !== 4'hD) begin bad++; $display("FAIL ar_values addr=%h code=%h exp 0/D", addr_a, code_a); end
        total++; if ({valid_a, nst_a, busy_a, done_a} !== 4'b0000) begin bad++; $display("FAIL ar_flags got=%b exp=0000", {valid_a, nst_a, busy_a, done_a}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tick_once();
        total++; if (busy_a !== 1'b0 || code_a !== 4'hD) begin bad++; $display("FAIL ar_tick_ignored busy=%b code=%h exp 0/D", busy_a, code_a); end
        @(negedge clk);
    endtask

    task automatic test_done();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        @(negedge clk);
        total++; if (code_b !== 4'h5 || nst_b !== 1'b1) begin bad++; $display("FAIL done_first code=%h nst=%b exp 5/1", code_b, nst_b); end
        for (int i = 0; i < 8; i++) begin
            tick_once();
            @(negedge clk);
        end
        total++; if (done_b !== 1'b1 || busy_b !== 1'b0) begin bad++; $display("FAIL done_state done=%b busy=%b exp 1/0", done_b, busy_b); end
        total++; if (code_b !== 4'hD || valid_b !== 1'b0) begin bad++; $display("FAIL done_note code=%h vld=%b exp D/0", code_b, valid_b); end
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        total++; if (done_b !== 1'b0 || busy_b !== 1'b1 || addr_b !== 4'd1) begin bad++; $display("FAIL done_restart done=%b busy=%b addr=%h exp 0/1/1", done_b, busy_b, addr_b); end
        @(negedge clk);
        total++; if (code_b !== 4'h5 || nst_b !== 1'b1 || valid_b !== 1'b1) begin bad++; $display("FAIL done_replay code=%h nst=%b vld=%b exp 5/1/1", code_b, nst_b, valid_b); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_phrase1();
        test_phrase2();
        test_loop();
        test_busy_start();
        test_stop();
        test_async_reset();
        test_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
